// File: rtl/unidad_control_pkg.sv
// +----------------------------------------------------------------------+
// | unidad_control_pkg: opcodes, FSM states and ALU codes shared by the  |
// | multicycle MIPS control unit.                       Revision: 1.0    |
// +----------------------------------------------------------------------+
`default_nettype none

package unidad_control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  typedef enum logic [3:0] {
    ST_RST      = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_MEM_ADDR = 4'd3,
    ST_MEM_RD   = 4'd4,
    ST_MEM_WB   = 4'd5,
    ST_MEM_WR   = 4'd6,
    ST_R_EX     = 4'd7,
    ST_R_WB     = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_JUMP     = 4'd10,
    ST_I_EX     = 4'd11,
    ST_I_WB     = 4'd12
  } state_e;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

endpackage

`default_nettype wire

// File: rtl/mem_wait_timer.sv
// +----------------------------------------------------------------------+
// | mem_wait_timer: counts memory wait cycles, flags a timeout.          |
// |                                                     Revision: 1.0    |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic ready,
  input  logic clear,
  output logic timeout
);

  localparam int              CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam bit              EN    = (MEM_TIMEOUT > 0);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // The current wait cycle is the MEM_TIMEOUT-th one when the count of earlier waits hits LIMIT.
  assign timeout = EN && active && !ready && (cnt_q == LIMIT);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear || ready || !active || timeout) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/unidad_control_multiciclo.sv
// +----------------------------------------------------------------------+
// | unidad_control_multiciclo: multicycle MIPS control FSM with          |
// | variable-latency memory handshake.                  Revision: 1.0    |
// +----------------------------------------------------------------------+
`default_nettype none

module unidad_control_multiciclo
  import unidad_control_pkg::*;
#(
  parameter int ALUOP_W     = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               mem_to_reg,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic               branch_ne,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_source,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               instr_done,
  output logic               illegal_op,
  output logic               mem_err,
  output logic [3:0]         state
);

  state_e     state_q;
  state_e     state_d;
  logic [5:0] op_q;
  logic [5:0] op_d;
  logic [1:0] alu_sel;
  logic       wait_active;
  logic       timeout;

  assign wait_active = (state_q == ST_FETCH) || (state_q == ST_MEM_RD) ||
                       (state_q == ST_MEM_WR);
  assign alu_op      = ALUOP_W'(alu_sel);
  assign state       = state_q;

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .active  (wait_active),
    .ready   (mem_ready),
    .clear   (state_d != state_q),
    .timeout (timeout)
  );

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    alu_sel       = ALU_ADD;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    branch_ne     = 1'b0;
    alu_src_b     = 2'b00;
    pc_source     = 2'b00;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    mem_err       = 1'b0;

    case (state_q)
      ST_RST: state_d = ST_FETCH;
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) begin
          state_d = ST_DECODE;
        end else if (timeout) begin
          mem_err = 1'b1;
        end
      end
      ST_DECODE: begin
        alu_src_b = 2'b11;
        op_d      = opcode;
        // Dispatch uses the live opcode; op_q only becomes valid next cycle.
        case (opcode)
          OP_LW, OP_SW:   state_d = ST_MEM_ADDR;
          OP_RTYPE:       state_d = ST_R_EX;
          OP_BEQ, OP_BNE: state_d = ST_BRANCH;
          OP_ADDI:        state_d = ST_I_EX;
          OP_J:           state_d = ST_JUMP;
          default: begin
            illegal_op = 1'b1;
            state_d    = ST_FETCH;
          end
        endcase
      end
      ST_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (op_q == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      end
      ST_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) begin
          state_d = ST_MEM_WB;
        end else if (timeout) begin
          mem_err = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = ST_FETCH;
        end else if (timeout) begin
          mem_err = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_R_EX: begin
        alu_src_a = 1'b1;
        alu_sel   = ALU_FUNCT;
        state_d   = ST_R_WB;
      end
      ST_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_sel       = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        branch_ne     = (op_q == OP_BNE);
        instr_done    = 1'b1;
        state_d       = ST_FETCH;
      end
      ST_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_I_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = ST_I_WB;
      end
      ST_I_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = ST_FETCH;
      end
      default: state_d = ST_RST;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RST;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_unidad_control_multiciclo.sv
// +----------------------------------------------------------------------+
// | tb_unidad_control_multiciclo: trace-based self-checking bench for    |
// | the multicycle control unit.                        Revision: 1.0    |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_unidad_control_multiciclo;

  localparam int TMO = 4;

  typedef struct packed {
    logic [3:0] st;
    logic [2:0] aluop;
    logic [1:0] srcb;
    logic [1:0] pcsrc;
    logic pcw, pcwc, iord, mrd, mwr, m2r, irw, rdst, rwr, srca, bne, done, ill, err;
  } ctl_t;

  typedef struct {
    logic       rdy;
    logic [5:0] opc;
    ctl_t       exp;
  } step_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, mem_to_reg;
  logic       ir_write, reg_dst, reg_write, alu_src_a, branch_ne;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;
  logic       instr_done, illegal_op, mem_err;
  logic [3:0] state;

  step_t trace[$];
  int    n_checks = 0;
  int    n_err    = 0;
  int    exp_done = 0;
  int    obs_done = 0;
  int    cyc      = 0;

  unidad_control_multiciclo #(
    .ALUOP_W     (3),
    .MEM_TIMEOUT (TMO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_to_reg    (mem_to_reg),
    .ir_write      (ir_write),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .branch_ne     (branch_ne),
    .alu_src_b     (alu_src_b),
    .pc_source     (pc_source),
    .alu_op        (alu_op),
    .instr_done    (instr_done),
    .illegal_op    (illegal_op),
    .mem_err       (mem_err),
    .state         (state)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic ctl_t pack_dut();
    ctl_t c;
    c.st = state;       c.aluop = alu_op;     c.srcb = alu_src_b;  c.pcsrc = pc_source;
    c.pcw = pc_write;   c.pcwc = pc_write_cond; c.iord = iord;     c.mrd = mem_read;
    c.mwr = mem_write;  c.m2r = mem_to_reg;   c.irw = ir_write;    c.rdst = reg_dst;
    c.rwr = reg_write;  c.srca = alu_src_a;   c.bne = branch_ne;   c.done = instr_done;
    c.ill = illegal_op; c.err = mem_err;
    return c;
  endfunction

  function automatic logic [5:0] rnd6();
    return 6'($urandom_range(0, 63));
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    return op inside {6'd0, 6'd2, 6'd4, 6'd5, 6'd8, 6'd35, 6'd43};
  endfunction

  task automatic push(input ctl_t e, input logic rdy, input logic [5:0] opc);
    step_t s;
    s.rdy = rdy;
    s.opc = opc;
    s.exp = e;
    trace.push_back(s);
  endtask

  // Expected cycle-by-cycle behaviour of one instruction; wf/wm are the
  // cycles mem_ready stays low in the fetch and data-memory phases.
  task automatic add_instr(input logic [5:0] op, input int wf, input int wm);
    ctl_t c;
    logic is_lw;
    for (int k = 1; k <= wf + 1; k++) begin
      c = '0; c.st = 4'd1; c.mrd = 1'b1; c.srcb = 2'b01;
      if (k == wf + 1) begin
        c.irw = 1'b1; c.pcw = 1'b1;
        push(c, 1'b1, rnd6());
      end else if (k == TMO) begin
        c.err = 1'b1;
        push(c, 1'b0, rnd6());
        return;
      end else begin
        push(c, 1'b0, rnd6());
      end
    end
    c = '0; c.st = 4'd2; c.srcb = 2'b11; c.ill = !is_legal(op);
    push(c, 1'($urandom_range(0, 1)), op);
    if (!is_legal(op)) return;
    case (op)
      6'd35, 6'd43: begin
        is_lw = (op == 6'd35);
        c = '0; c.st = 4'd3; c.srca = 1'b1; c.srcb = 2'b10;
        push(c, 1'($urandom_range(0, 1)), rnd6());
        for (int k = 1; k <= wm + 1; k++) begin
          c = '0; c.st = is_lw ? 4'd4 : 4'd6; c.iord = 1'b1;
          c.mrd = is_lw; c.mwr = !is_lw;
          if (k == wm + 1) begin
            c.done = !is_lw;
            push(c, 1'b1, rnd6());
          end else if (k == TMO) begin
            c.err = 1'b1;
            push(c, 1'b0, rnd6());
            return;
          end else begin
            push(c, 1'b0, rnd6());
          end
        end
        if (is_lw) begin
          c = '0; c.st = 4'd5; c.rwr = 1'b1; c.m2r = 1'b1; c.done = 1'b1;
          push(c, 1'($urandom_range(0, 1)), rnd6());
        end
      end
      6'd0: begin
        c = '0; c.st = 4'd7; c.srca = 1'b1; c.aluop = 3'd2;
        push(c, 1'($urandom_range(0, 1)), rnd6());
        c = '0; c.st = 4'd8; c.rwr = 1'b1; c.rdst = 1'b1; c.done = 1'b1;
        push(c, 1'($urandom_range(0, 1)), rnd6());
      end
      6'd4, 6'd5: begin
        c = '0; c.st = 4'd9; c.srca = 1'b1; c.aluop = 3'd1; c.pcwc = 1'b1;
        c.pcsrc = 2'b01; c.bne = (op == 6'd5); c.done = 1'b1;
        push(c, 1'($urandom_range(0, 1)), rnd6());
      end
      6'd2: begin
        c = '0; c.st = 4'd10; c.pcw = 1'b1; c.pcsrc = 2'b10; c.done = 1'b1;
        push(c, 1'($urandom_range(0, 1)), rnd6());
      end
      default: begin
        c = '0; c.st = 4'd11; c.srca = 1'b1; c.srcb = 2'b10;
        push(c, 1'($urandom_range(0, 1)), rnd6());
        c = '0; c.st = 4'd12; c.rwr = 1'b1; c.done = 1'b1;
        push(c, 1'($urandom_range(0, 1)), rnd6());
      end
    endcase
    exp_done++;
  endtask

  task automatic run_trace(input int max_steps);
    step_t s;
    int    n = 0;
    while (trace.size() > 0 && n < max_steps) begin
      s = trace.pop_front();
      n++;
      @(posedge clk);
      #1;
      mem_ready = s.rdy;
      opcode    = s.opc;
      @(negedge clk);
      cyc++;
      chk_eq($sformatf("cyc%0d", cyc), 32'(pack_dut()), 32'(s.exp));
      if (instr_done) obs_done++;
    end
  endtask

  initial begin
    logic [5:0] op;
    int         wf;
    rst_n     = 1'b0;
    opcode    = 6'd0;
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_eq("reset", 32'(pack_dut()), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_eq("rst_release", 32'(pack_dut()), 32'd0);

    add_instr(6'd0, 0, 0);
    add_instr(6'd35, 0, 3);
    add_instr(6'd5, 0, 0);
    add_instr(6'd4, 0, 0);
    add_instr(6'd2, 0, 0);
    add_instr(6'd63, 0, 0);
    add_instr(6'd43, 0, 10);
    add_instr(6'd43, 0, 3);
    add_instr(6'd8, 2, 0);
    add_instr(6'd0, 9, 0);
    add_instr(6'd35, 3, 4);
    run_trace(100000);

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 7))
        0: op = 6'd0;
        1: op = 6'd2;
        2: op = 6'd4;
        3: op = 6'd5;
        4: op = 6'd8;
        5: op = 6'd35;
        6: op = 6'd43;
        default: begin
          op = rnd6();
          if (is_legal(op)) op = 6'd63;
        end
      endcase
      wf = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
      add_instr(op, wf, $urandom_range(0, 5));
    end
    run_trace(100000);

    // Abort an lw while it waits in MEM_RD.
    add_instr(6'd35, 0, 10);
    run_trace(5);
    trace.delete();
    #2 mem_ready = 1'b1;
    rst_n = 1'b0;
    #1 chk_eq("rst_async", 32'(pack_dut()), 32'd0);
    @(negedge clk);
    chk_eq("rst_hold", 32'(pack_dut()), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_eq("rst_release2", 32'(pack_dut()), 32'd0);
    add_instr(6'd0, 0, 0);
    run_trace(100000);

    chk_eq("done_count", 32'(obs_done), 32'(exp_done));
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
